rv_csr_file: RTL

Machine-mode CSR file for the RV32/RV64 core, the next generation of the read-only counter block. It adds writable machine counters, `mcountinhibit`, `mscratch`, a parametrised set of hardware performance counters, CSRRW/CSRRS/CSRRC write semantics and illegal-access detection. It sits beside the execute stage: reads are combinational in the issuing cycle, and writes commit on the next clock edge.

---
 rtl/rv_csr_pkg.sv | 49 ++++
 rtl/rv_csr_counter.sv | 36 +++
 rtl/rv_csr_file.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/rv_csr_pkg.sv
// Shared definitions for the machine-mode CSR file: CSR addresses, write operations,
// counter half-select codes, mcountinhibit bit positions and the misa constant.
package rv_csr_pkg;

   localparam logic [11:0] CSR_MISA          = 12'h301;
   localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
   localparam logic [11:0] CSR_MSCRATCH      = 12'h340;
   localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
   localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
   localparam logic [11:0] CSR_MHPMCOUNTER3  = 12'hB03;
   localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
   localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
   localparam logic [11:0] CSR_MHPMCOUNTER3H = 12'hB83;
   localparam logic [11:0] CSR_CYCLE         = 12'hC00;
   localparam logic [11:0] CSR_TIME          = 12'hC01;
   localparam logic [11:0] CSR_INSTRET       = 12'hC02;
   localparam logic [11:0] CSR_HPMCOUNTER3   = 12'hC03;
   localparam logic [11:0] CSR_CYCLEH        = 12'hC80;
   localparam logic [11:0] CSR_TIMEH         = 12'hC81;
   localparam logic [11:0] CSR_INSTRETH      = 12'hC82;
   localparam logic [11:0] CSR_HPMCOUNTER3H  = 12'hC83;

   typedef enum logic [1:0] {
      OP_WRITE = 2'b00,
      OP_SET   = 2'b01,
      OP_CLEAR = 2'b10
   } csr_op_t;

   typedef enum logic [1:0] {
      WR_FULL = 2'b00,
      WR_LOW  = 2'b01,
      WR_HIGH = 2'b10
   } wr_sel_t;

   localparam int INH_CY   = 0;
   localparam int INH_IR   = 2;
   localparam int INH_HPM3 = 3;
   localparam logic [31:0] INH_FIXED = 32'h0000_0005;

   // MXL field in the top two bits, extensions I, C and B
   function automatic logic [63:0] misa_value(input logic is_rv64);
      if (is_rv64) begin
         return 64'h8000_0000_0000_0106;
      end else begin
         return 64'h0000_0000_4000_0106;
      end
   endfunction

endpackage

// File: rtl/rv_csr_counter.sv
// One 64-bit machine counter: increments by inc unless inhibited, and a software write
// (full, low half or high half) lands exactly and suppresses that cycle's increment.
module rv_csr_counter
   import rv_csr_pkg::*;
#(
   parameter int INC_W = 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             inhibit,
   input  logic [INC_W-1:0] inc,
   input  logic             wr_en,
   input  logic [1:0]       wr_sel,
   input  logic [63:0]      wr_data,
   output logic [63:0]      value
);

   // counter register: write has priority over increment
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         value <= 64'h0;
      end else if (wr_en) begin
         case (wr_sel)
            WR_FULL: value <= wr_data;
            WR_LOW:  value <= {value[63:32], wr_data[31:0]};
            WR_HIGH: value <= {wr_data[63:32], value[31:0]};
            default: value <= value;
         endcase
      end else if (!inhibit) begin
         value <= value + {{(64-INC_W){1'b0}}, inc};
      end else begin
         value <= value;
      end
   end

endmodule

// File: rtl/rv_csr_file.sv
// Machine-mode CSR file: counters, mcountinhibit, mscratch and misa with CSRRW/S/C
// write semantics; reads and illegal-access detection are combinational.
module rv_csr_file
   import rv_csr_pkg::*;
#(
   parameter int rv64       = 1,
   parameter int num_hpm    = 4,
   parameter int max_retire = 2,
   localparam int XLEN  = (rv64 != 0) ? 64 : 32,
   localparam int RC_W  = $clog2(max_retire + 1),
   localparam int HPM_W = (num_hpm > 0) ? num_hpm : 1
) (
   input  logic            clock,
   input  logic            reset,
   input  logic [63:0]     time_,
   input  logic [11:0]     csr,
   input  logic            load,
   input  logic            store,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] store_value,
   input  logic [RC_W-1:0] retire_count,
   input  logic [HPM_W-1:0] hpm_event,
   output logic            sigill,
   output logic [XLEN-1:0] load_value
);

   localparam logic [63:0] MISA = misa_value(rv64 != 0);
   localparam logic [31:0] INH_MASK = INH_FIXED | (((32'h1 << num_hpm) - 32'h1) << INH_HPM3);

   logic [63:0]     cnt_s [32];
   logic [31:0]     inh_r;
   logic [XLEN-1:0] scratch_r;
   logic [4:0]      idx_s;
   logic            misa_hit_s, inh_hit_s, scr_hit_s, cnt_hit_s, time_hit_s, hi_s;
   logic            legal_s, sigill_s, wr_ok_s;
   logic [63:0]     src64_s, rd64_s, wr64_s;
   logic [XLEN-1:0] old_s, new_s;
   wr_sel_t         wr_sel_s;

   // address decode; counter index 0 = cycle, 1 = instret, 2+i = hpm(3+i)
   always_comb begin
      misa_hit_s = (csr == CSR_MISA);
      inh_hit_s  = (csr == CSR_MCOUNTINHIBIT);
      scr_hit_s  = (csr == CSR_MSCRATCH);
      cnt_hit_s  = 1'b0;
      time_hit_s = 1'b0;
      idx_s      = 5'd0;
      hi_s       = csr[7];
      if ((csr[11:8] == CSR_MCYCLE[11:8] || csr[11:8] == CSR_CYCLE[11:8]) &&
          csr[6:5] == 2'b00 && (!csr[7] || rv64 == 0)) begin
         if (csr[4:0] == 5'd0) begin
            cnt_hit_s = 1'b1;
            idx_s     = 5'd0;
         end else if (csr[4:0] == 5'd1) begin
            time_hit_s = (csr[11:8] == CSR_TIME[11:8]);
         end else if (csr[4:0] == 5'd2) begin
            cnt_hit_s = 1'b1;
            idx_s     = 5'd1;
         end else if (int'(csr[4:0]) < 3 + num_hpm) begin
            cnt_hit_s = 1'b1;
            idx_s     = csr[4:0] - 5'd1;
         end else begin
            cnt_hit_s = 1'b0;
         end
      end else begin
         cnt_hit_s = 1'b0;
      end
   end

   // read mux, legality and write-data computation from the old value
   always_comb begin
      if (time_hit_s) begin
         src64_s = time_;
      end else begin
         src64_s = cnt_s[idx_s];
      end
      rd64_s = 64'h0;
      if (misa_hit_s) begin
         rd64_s = MISA;
      end else if (inh_hit_s) begin
         rd64_s = {32'h0, inh_r};
      end else if (scr_hit_s) begin
         rd64_s[XLEN-1:0] = scratch_r;
      end else if (cnt_hit_s || time_hit_s) begin
         rd64_s = hi_s ? {32'h0, src64_s[63:32]} : src64_s;
      end else begin
         rd64_s = 64'h0;
      end
      legal_s  = misa_hit_s | inh_hit_s | scr_hit_s | cnt_hit_s | time_hit_s;
      sigill_s = (load | store) &&
                 (!legal_s || (store && csr[11:10] == 2'b11) || (store && op == 2'b11));
      wr_ok_s  = store && !sigill_s;
      old_s    = rd64_s[XLEN-1:0];
      case (csr_op_t'(op))
         OP_WRITE: new_s = store_value;
         OP_SET:   new_s = old_s | store_value;
         OP_CLEAR: new_s = old_s & ~store_value;
         default:  new_s = old_s;
      endcase
      // RV32 half writes see the operand in both halves; the counter picks one
      wr64_s = {(64/XLEN){new_s}};
      if (rv64 != 0) begin
         wr_sel_s = WR_FULL;
      end else if (hi_s) begin
         wr_sel_s = WR_HIGH;
      end else begin
         wr_sel_s = WR_LOW;
      end
   end

   assign sigill     = sigill_s;
   assign load_value = load ? rd64_s[XLEN-1:0] : 'x;

   // mscratch and mcountinhibit; inhibit change applies from the following cycle
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         scratch_r <= '0;
         inh_r     <= 32'h0;
      end else begin
         if (wr_ok_s && scr_hit_s) begin
            scratch_r <= new_s;
         end else begin
            scratch_r <= scratch_r;
         end
         if (wr_ok_s && inh_hit_s) begin
            inh_r <= new_s[31:0] & INH_MASK;
         end else begin
            inh_r <= inh_r;
         end
      end
   end

   for (genvar k = 0; k < 32; k++) begin : g_cnt
      if (k < num_hpm + 2) begin : g_on
         logic [RC_W-1:0] inc_s;
         if (k == 0) begin : g_cy
            assign inc_s = RC_W'(1'b1);
         end else if (k == 1) begin : g_ir
            assign inc_s = retire_count;
         end else begin : g_hpm
            assign inc_s = RC_W'(hpm_event[k-2]);
         end
         rv_csr_counter #(.INC_W(RC_W)) u_counter (
            .clock   (clock),
            .reset   (reset),
            .inhibit (inh_r[(k == 0) ? INH_CY : (k == 1) ? INH_IR : INH_HPM3 + k - 2]),
            .inc     (inc_s),
            .wr_en   (wr_ok_s && cnt_hit_s && (idx_s == 5'(k))),
            .wr_sel  (wr_sel_s),
            .wr_data (wr64_s),
            .value   (cnt_s[k])
         );
      end else begin : g_off
         assign cnt_s[k] = 64'h0;
      end
   end

endmodule
